// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32-subset core with one shared req/ready memory port.
// One instruction takes 3-5 states; faults halt the core with a sticky cause code.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [1:0]  cause,
    output logic [31:0] pc_out,
    output logic        retire
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] regs_q [32];
    logic        rf_we;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, wr_addr;
    logic        is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, legal;
    logic [31:0] alu_b, sum, diff, alu_res, pc_plus4, br_target, j_target;
    logic        add_ovf, sub_ovf, ovf, taken;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign is_rtype = (opcode == 6'h00);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_bne   = (opcode == 6'h05);
    assign is_j     = (opcode == 6'h02);
    assign wr_addr  = is_rtype ? rd : rt;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h2A, 6'h2B, 6'h00, 6'h02: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // R-type uses rt as the second operand, every I-type uses the extended immediate.
    assign alu_b     = is_rtype ? b_q : imm_q;
    assign sum       = a_q + alu_b;
    assign diff      = a_q - b_q;
    assign add_ovf   = (a_q[31] == alu_b[31]) && (sum[31] != a_q[31]);
    assign sub_ovf   = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign taken     = is_beq ? (a_q == b_q) : (a_q != b_q);

    always_comb begin
        alu_res = sum;
        ovf     = 1'b0;
        if (is_rtype) begin
            case (funct)
                6'h20: begin alu_res = sum; ovf = add_ovf; end
                6'h22: begin alu_res = diff; ovf = sub_ovf; end
                6'h23: alu_res = diff;
                6'h24: alu_res = a_q & alu_b;
                6'h25: alu_res = a_q | alu_b;
                6'h2A: alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
                6'h2B: alu_res = {31'b0, a_q < alu_b};
                6'h00: alu_res = b_q << shamt;
                6'h02: alu_res = b_q >> shamt;
                default: alu_res = sum;
            endcase
        end else begin
            case (opcode)
                6'h08: begin alu_res = sum; ovf = add_ovf; end
                6'h0A: alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
                6'h0C: alu_res = a_q & alu_b;
                6'h0D: alu_res = a_q | alu_b;
                6'h0F: alu_res = {ir_q[15:0], 16'h0000};
                default: alu_res = sum;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        res_d     = res_q;
        cause_d   = cause_q;
        rf_we     = 1'b0;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
                b_d   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
                imm_d = (opcode == 6'h0C || opcode == 6'h0D) ? {16'h0000, ir_q[15:0]}
                                                               : {{16{ir_q[15]}}, ir_q[15:0]};
                if (!legal) begin
                    cause_d = 2'd1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    if (sum[1:0] != 2'b00) begin
                        cause_d = 2'd3;
                        state_d = S_HALT;
                    end else begin
                        res_d   = sum;
                        state_d = S_MEM;
                    end
                end else if (is_beq || is_bne) begin
                    pc_d    = taken ? br_target : pc_plus4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_d    = j_target;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (ovf) begin
                    cause_d = 2'd2;
                    state_d = S_HALT;
                end else begin
                    res_d   = alu_res;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = res_q;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_plus4;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign cause     = cause_q;
    assign pc_out    = pc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            imm_q   <= 32'd0;
            res_q   <= 32'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            cause_q <= cause_d;
        end
    end

    // $0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (rf_we && wr_addr != 5'd0) begin
            regs_q[wr_addr] <= res_q;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a word memory,
// results checked against hand-computed values with immediate assertions.
module tb_mips_multicycle_core;
    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [1:0]  cause;

    logic [31:0] tb_mem [0:63];
    logic        stall_mode;
    int          wait_cnt = 0;
    int          cyc = 0;
    int          st_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    int          ret_cyc [$];
    logic [31:0] ret_pc [$];

    int n_cmp = 0;
    int n_mis = 0;
    int rel, rbase, sbase, qbase, stall40;
    logic        prev_stall, found;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    mips_multicycle_core #(.RESET_PC(32'h0000_0000)) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .halted   (halted),
        .cause    (cause),
        .pc_out   (pc_out),
        .retire   (retire)
    );

    always #5 clock = ~clock;

    // Slow-memory mode holds ready low for two cycles of every request.
    assign mem_ready = !stall_mode || (wait_cnt >= 2);
    assign mem_rdata = tb_mem[mem_addr[7:2]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) wait_cnt <= 0;
        else if (mem_req && mem_ready) wait_cnt <= 0;
        else if (mem_req) wait_cnt <= wait_cnt + 1;
        if (!reset && mem_req) req_cnt <= req_cnt + 1;
        if (!reset && mem_req && mem_we && mem_ready) begin
            st_cnt  <= st_cnt + 1;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
        if (!reset && retire) begin
            ret_cyc.push_back(cyc + 1);
            ret_pc.push_back(pc_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'd0;
    endtask

    task automatic start(input logic stall);
        reset = 1'b1;
        stall_mode = stall;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        rel   = cyc;
        rbase = ret_cyc.size();
        sbase = st_cnt;
        qbase = req_cnt;
    endtask

    task automatic run_halt(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (halted) break;
        end
    endtask

    initial begin
        reset = 1'b1;
        stall_mode = 1'b0;
        clear_mem();
        tb_mem[0] = 32'h2001_0005;  // addi $1,$0,5
        tb_mem[1] = 32'h2002_FFFD;  // addi $2,$0,-3
        tb_mem[2] = 32'h0022_1820;  // add  $3,$1,$2
        tb_mem[3] = 32'hAC03_0000;  // sw   $3,0($0)
        tb_mem[4] = 32'hFC00_0000;  // opcode 0x3F
        @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        reset = 1'b0;
        rel = cyc; rbase = ret_cyc.size(); sbase = st_cnt;
        @(negedge clock);
        chk("first_fetch_req", 32'(mem_req), 32'd1);
        chk("first_fetch_addr", mem_addr, 32'd0);
        run_halt(100);
        chk("alu_halted", 32'(halted), 32'd1);
        chk("alu_cause_illegal", 32'(cause), 32'd1);
        chk("alu_halt_pc", pc_out, 32'd16);
        chk("alu_store_count", 32'(st_cnt - sbase), 32'd1);
        chk("alu_store_addr", st_addr, 32'd0);
        chk("alu_store_data", st_data, 32'd2);
        chk("alu_retire_count", 32'(ret_cyc.size() - rbase), 32'd4);
        chk("alu_first_retire", 32'(ret_cyc[rbase] - rel), 32'd5);
        for (int i = 1; i < 4; i++)
            chk($sformatf("alu_cpi_%0d", i), 32'(ret_cyc[rbase+i] - ret_cyc[rbase+i-1]), 32'd4);
        chk("halt_req", 32'(mem_req), 32'd0);
        chk("halt_retire", 32'(retire), 32'd0);
        $display("txn alu_sequence retires=%0d store=%h@%h", ret_cyc.size() - rbase, st_data, st_addr);

        // lw/sw through a slow memory
        clear_mem();
        tb_mem[0]  = 32'h8C04_0040; // lw $4,0x40($0)
        tb_mem[1]  = 32'hAC04_0044; // sw $4,0x44($0)
        tb_mem[2]  = 32'hFC00_0000;
        tb_mem[16] = 32'hDEAD_BEEF;
        start(1'b1);
        prev_stall = 1'b0; stall40 = 0;
        prev_addr = 32'd0; prev_we = 1'b0; prev_wdata = 32'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (prev_stall && mem_req) begin
                chk("stall_addr_stable", mem_addr, prev_addr);
                chk("stall_we_stable", 32'(mem_we), 32'(prev_we));
                chk("stall_wdata_stable", mem_wdata, prev_wdata);
            end
            if (mem_req && !mem_ready && !mem_we && mem_addr == 32'h40) stall40++;
            prev_stall = mem_req && !mem_ready;
            prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
            if (halted) break;
        end
        chk("lw_halted", 32'(halted), 32'd1);
        chk("lw_stall_cycles", 32'(stall40), 32'd2);
        chk("lw_retire_time", 32'(ret_cyc[rbase] - rel), 32'd10);
        chk("sw_stalled_cpi", 32'(ret_cyc[rbase+1] - ret_cyc[rbase]), 32'd8);
        chk("lw_reg4", dut.regs_q[4], 32'hDEAD_BEEF);
        chk("lw_store_addr", st_addr, 32'h44);
        chk("lw_store_data", st_data, 32'hDEAD_BEEF);
        $display("txn lw_stall reg4=%h store=%h@%h", dut.regs_q[4], st_data, st_addr);

        // j / beq taken back / j / bne not taken
        clear_mem();
        tb_mem[0] = 32'h0800_0004;  // j 16
        tb_mem[3] = 32'h0800_0006;  // j 24
        tb_mem[4] = 32'h1000_FFFE;  // beq $0,$0,-2 -> 12
        tb_mem[6] = 32'h1400_0005;  // bne $0,$0,5 -> not taken
        tb_mem[7] = 32'hFC00_0000;
        start(1'b0);
        run_halt(100);
        chk("br_retire_count", 32'(ret_cyc.size() - rbase), 32'd4);
        chk("br_first_retire", 32'(ret_cyc[rbase] - rel), 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("br_cpi_%0d", i), 32'(ret_cyc[rbase+i] - ret_cyc[rbase+i-1]), 32'd3);
        chk("br_pc_0", ret_pc[rbase], 32'd0);
        chk("br_pc_1", ret_pc[rbase+1], 32'd16);
        chk("br_pc_2", ret_pc[rbase+2], 32'd12);
        chk("br_pc_3", ret_pc[rbase+3], 32'd24);
        chk("bne_fallthrough_pc", pc_out, 32'd28);
        $display("txn branches halt_pc=%h", pc_out);

        // signed overflow on addi
        clear_mem();
        tb_mem[0] = 32'h2002_0007;  // addi $2,$0,7
        tb_mem[1] = 32'h3C01_7FFF;  // lui  $1,0x7FFF
        tb_mem[2] = 32'h3421_FFFF;  // ori  $1,$1,0xFFFF
        tb_mem[3] = 32'h2022_0001;  // addi $2,$1,1
        start(1'b0);
        run_halt(100);
        repeat (5) @(negedge clock);
        chk("ovf_halted", 32'(halted), 32'd1);
        chk("ovf_cause", 32'(cause), 32'd2);
        chk("ovf_pc", pc_out, 32'd12);
        chk("ovf_reg1", dut.regs_q[1], 32'h7FFF_FFFF);
        chk("ovf_reg2_kept", dut.regs_q[2], 32'd7);
        chk("ovf_retires", 32'(ret_cyc.size() - rbase), 32'd3);
        chk("ovf_req_cycles", 32'(req_cnt - qbase), 32'd4);
        $display("txn overflow cause=%0d pc=%h", cause, pc_out);

        // ALU mix, ending on an illegal funct
        clear_mem();
        tb_mem[0] = 32'h2001_FFFF;  // addi $1,$0,-1
        tb_mem[1] = 32'h0020_102A;  // slt  $2,$1,$0
        tb_mem[2] = 32'h0020_182B;  // sltu $3,$1,$0
        tb_mem[3] = 32'h0001_2100;  // sll  $4,$1,4
        tb_mem[4] = 32'h0001_2F02;  // srl  $5,$1,28
        tb_mem[5] = 32'h3026_8001;  // andi $6,$1,0x8001
        tb_mem[6] = 32'h00A4_3822;  // sub  $7,$5,$4
        tb_mem[7] = 32'h0000_003F;  // undefined funct
        start(1'b0);
        run_halt(200);
        chk("mix_reg1", dut.regs_q[1], 32'hFFFF_FFFF);
        chk("mix_slt", dut.regs_q[2], 32'd1);
        chk("mix_sltu", dut.regs_q[3], 32'd0);
        chk("mix_sll", dut.regs_q[4], 32'hFFFF_FFF0);
        chk("mix_srl", dut.regs_q[5], 32'h0000_000F);
        chk("mix_andi", dut.regs_q[6], 32'h0000_8001);
        chk("mix_sub", dut.regs_q[7], 32'h0000_001F);
        chk("mix_cause", 32'(cause), 32'd1);
        chk("mix_pc", pc_out, 32'd28);
        $display("txn alu_mix cause=%0d pc=%h", cause, pc_out);

        // misaligned load
        clear_mem();
        tb_mem[0] = 32'h8C01_0002;  // lw $1,2($0)
        start(1'b0);
        run_halt(50);
        chk("mis_cause", 32'(cause), 32'd3);
        chk("mis_pc", pc_out, 32'd0);
        chk("mis_req_cycles", 32'(req_cnt - qbase), 32'd1);
        chk("mis_retires", 32'(ret_cyc.size() - rbase), 32'd0);
        $display("txn misaligned cause=%0d", cause);

        // reset while a load is stalled in MEM
        clear_mem();
        tb_mem[0] = 32'h8C04_0040;
        tb_mem[16] = 32'h1234_5678;
        start(1'b1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 32'h40) begin
                found = 1'b1;
                break;
            end
        end
        chk("mem_phase_reached", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_reg4", dut.regs_q[4], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        stall_mode = 1'b0;
        @(negedge clock);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'd0);
        $display("txn reset_mid_mem restart_addr=%h", mem_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
